vecmem_sample_streamer: RTL and testbench

- Read-side counterpart to the processor's vector writes into the vector data memory.
- Once started, fetches consecutive 128-bit words through the memory's vector read port (address + q).
- Serializes each word into sixteen 8-bit audio samples on a valid/ready stream, for the audio output/DAC path or a debug UART.
- Walks a block of `word_count` words starting at `base_addr`, then signals completion.

---
 rtl/vecmem_sample_streamer_if.sv | 28 ++
 rtl/vecmem_sample_streamer.sv | 137 +++++++++++++
 tb/tb_vecmem_sample_streamer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/vecmem_sample_streamer_if.sv
// Bundle of the streamer's control, vector-RAM read port and sample stream.
// The streamer uses the slave modport; whatever drives and consumes it
// (integration glue or a bench) uses the master modport.
interface vecmem_sample_streamer_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 128
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_q;
  logic [7:0]        sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              busy;
  logic              done;

  modport slave (
    input  start, base_addr, word_count, mem_q, sample_ready,
    output mem_addr, sample_data, sample_valid, busy, done
  );

  modport master (
    output start, base_addr, word_count, mem_q, sample_ready,
    input  mem_addr, sample_data, sample_valid, busy, done
  );
endinterface

// File: rtl/vecmem_sample_streamer.sv
// Reads a block of consecutive vector-RAM words and serializes each word,
// least significant byte first, onto an 8-bit valid/ready sample stream.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; zero-length start just pulses done
// FETCH  | mem_addr presented, down-counting RAM latency before capturing q
// STREAM | holding register being emitted one byte per accepted handshake
module vecmem_sample_streamer #(
  parameter int ADDR_W      = 14,
  parameter int DATA_W      = 128,
  parameter int MEM_LATENCY = 1
) (
  input logic                   clk,
  input logic                   reset,
  vecmem_sample_streamer_if.slave bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  // The counter is loaded with MEM_LATENCY and captures on terminal count,
  // giving MEM_LATENCY+1 edges between the address update and the capture.
  localparam logic [1:0] WAIT_LOAD = 2'(MEM_LATENCY);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    STREAM = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]           remaining_q, remaining_d;
  logic [1:0]                  wait_q, wait_d;
  logic [NBYTES-1:0][7:0]      hold_q, hold_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;

  assign bus.mem_addr     = mem_addr_q;
  assign bus.sample_data  = hold_q[idx_q];
  assign bus.sample_valid = valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

  // State and datapath registers; reset clears everything, discarding any
  // partially streamed word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      remaining_q <= '0;
      wait_q      <= '0;
      hold_q      <= '0;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      remaining_q <= remaining_d;
      wait_q      <= wait_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state and datapath updates; done is a single-cycle pulse by default.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.word_count != '0) begin
            remaining_d = bus.word_count;
            mem_addr_d  = bus.base_addr;
            wait_d      = WAIT_LOAD;
            busy_d      = 1'b1;
            state_d     = FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      FETCH: begin
        valid_d = 1'b0;
        if (wait_q == 2'd0) begin
          hold_d  = bus.mem_q;
          idx_d   = '0;
          valid_d = 1'b1;
          state_d = STREAM;
        end else begin
          wait_d = wait_q - 2'd1;
        end
      end

      STREAM: begin
        if (valid_q && bus.sample_ready) begin
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            if (remaining_q == ADDR_W'(1)) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              // Address wraps naturally at 2^ADDR_W.
              remaining_d = remaining_q - ADDR_W'(1);
              mem_addr_d  = mem_addr_q + ADDR_W'(1);
              wait_d      = WAIT_LOAD;
              state_d     = FETCH;
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vecmem_sample_streamer.sv
// Bench for vecmem_sample_streamer: one instance at RAM latency 1, one at 2.
module tb_vecmem_sample_streamer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  vecmem_sample_streamer_if #(.ADDR_W(14), .DATA_W(128)) bus1 ();
  vecmem_sample_streamer_if #(.ADDR_W(14), .DATA_W(128)) bus2 ();

  vecmem_sample_streamer #(.ADDR_W(14), .DATA_W(128), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  vecmem_sample_streamer #(.ADDR_W(14), .DATA_W(128), .MEM_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: byte i of the word at address A is {A[3:0], i[3:0]}.
  function automatic logic [127:0] ram_word(input logic [13:0] a);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = {a[3:0], 4'(i)};
    return w;
  endfunction

  logic [127:0] q2_pipe;
  always @(posedge clk) begin
    bus1.mem_q <= ram_word(bus1.mem_addr);
    q2_pipe    <= ram_word(bus2.mem_addr);
    bus2.mem_q <= q2_pipe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_start(input int which, input logic s, input logic [13:0] b, input logic [13:0] c);
    if (which == 0) begin
      bus1.start = s; bus1.base_addr = b; bus1.word_count = c;
    end else begin
      bus2.start = s; bus2.base_addr = b; bus2.word_count = c;
    end
  endtask

  // mode: 0 ready always, 1 ready on odd cycles, 2 ready every third cycle.
  // inj>0: pulse a conflicting start at that cycle of the transfer.
  task automatic run_stream(input int which, input logic [13:0] base, input logic [13:0] cnt,
                            input int mode, input int inj, input logic [7:0] exp_first,
                            input logic [13:0] exp_last);
    int lat, total, limit, got, n, first_n, last_acc, gap;
    bit seen_done;
    logic pv, pr, v, r, dn, bz;
    logic [7:0] pd, d, exp_b;
    logic [13:0] a;
    lat = (which == 0) ? 1 : 2;
    total = 16 * int'(cnt);
    limit = total * 4 + 50;
    got = 0; n = 0; first_n = -1; last_acc = -1; gap = 0;
    seen_done = 0; pv = 0; pr = 0; pd = '0;
    @(negedge clk);
    drive_start(which, 1'b1, base, cnt);
    while (!seen_done && n < limit) begin
      @(negedge clk);
      n++;
      if (n == 1) drive_start(which, 1'b0, base, cnt);
      if (inj > 0 && n == inj) drive_start(which, 1'b1, 14'h0700, 14'd5);
      if (inj > 0 && n == inj + 1) drive_start(which, 1'b0, 14'h0700, 14'd5);
      v  = (which == 0) ? bus1.sample_valid : bus2.sample_valid;
      d  = (which == 0) ? bus1.sample_data  : bus2.sample_data;
      dn = (which == 0) ? bus1.done         : bus2.done;
      bz = (which == 0) ? bus1.busy         : bus2.busy;
      a  = (which == 0) ? bus1.mem_addr     : bus2.mem_addr;
      case (mode)
        0: r = 1'b1;
        1: r = n[0];
        default: r = (n % 3 == 0);
      endcase
      bus1.sample_ready = r;
      bus2.sample_ready = r;

      if (pv && !pr) begin
        chk("hold_valid", 32'(v), 32'd1);
        chk("hold_data", 32'(d), 32'(pd));
      end
      if (v && first_n < 0) begin
        first_n = n;
        chk("first_valid_cycle", 32'(n), 32'(lat + 2));
        chk("busy_streaming", 32'(bz), 32'd1);
      end
      if (v && !pv) chk("word_addr", 32'(a), 32'(14'(base + 14'(got / 16))));
      if (v && gap > 0) begin
        chk("word_gap", 32'(gap), 32'(lat + 1));
        gap = 0;
      end
      if (!v && got > 0 && got < total) gap++;
      if (v && r) begin
        exp_b = 8'(int'(exp_first) + got);
        chk("sample_byte", 32'(d), 32'(exp_b));
        got++;
        last_acc = n;
      end
      if (dn) begin
        seen_done = 1;
        chk("done_timing", 32'(n), 32'(last_acc + 1));
        chk("busy_at_done", 32'(bz), 32'd0);
      end
      pv = v; pr = r; pd = d;
    end
    chk("done_seen", 32'(seen_done), 32'd1);
    chk("byte_total", 32'(got), 32'(total));
    chk("final_addr", 32'(a), 32'(exp_last));
    @(negedge clk);
    dn = (which == 0) ? bus1.done : bus2.done;
    chk("done_pulse_width", 32'(dn), 32'd0);
  endtask

  typedef struct {
    int          which;
    logic [13:0] base;
    logic [13:0] cnt;
    int          mode;
    int          inj;
    logic [7:0]  exp_first;
    logic [13:0] exp_last;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [13:0] addr_before;
    bit hit;
    bit bad_done;

    vecs[0] = '{0, 14'h0010, 14'd1, 0, 0,  8'h00, 14'h0010};
    vecs[1] = '{0, 14'h0100, 14'd3, 1, 0,  8'h00, 14'h0102};
    vecs[2] = '{1, 14'h3FFF, 14'd2, 0, 0,  8'hF0, 14'h0000};
    vecs[3] = '{0, 14'h0025, 14'd2, 0, 10, 8'h50, 14'h0026};
    vecs[4] = '{1, 14'h0041, 14'd2, 2, 0,  8'h10, 14'h0042};

    reset = 1'b1;
    drive_start(0, 1'b0, 14'h0, 14'h0);
    drive_start(1, 1'b0, 14'h0, 14'h0);
    bus1.sample_ready = 1'b0;
    bus2.sample_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_addr1", 32'(bus1.mem_addr), 32'd0);
    chk("rst_data1", 32'(bus1.sample_data), 32'd0);
    chk("rst_valid1", 32'(bus1.sample_valid), 32'd0);
    chk("rst_busy1", 32'(bus1.busy), 32'd0);
    chk("rst_done1", 32'(bus1.done), 32'd0);
    chk("rst_valid2", 32'(bus2.sample_valid), 32'd0);
    chk("rst_busy2", 32'(bus2.busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 5; k++)
      run_stream(vecs[k].which, vecs[k].base, vecs[k].cnt, vecs[k].mode, vecs[k].inj,
                 vecs[k].exp_first, vecs[k].exp_last);

    // Zero-length request: done pulse only, nothing else moves.
    addr_before = bus1.mem_addr;
    drive_start(0, 1'b1, 14'h0123, 14'd0);
    @(negedge clk);
    drive_start(0, 1'b0, 14'h0123, 14'd0);
    chk("zero_done", 32'(bus1.done), 32'd1);
    chk("zero_busy", 32'(bus1.busy), 32'd0);
    chk("zero_valid", 32'(bus1.sample_valid), 32'd0);
    chk("zero_addr", 32'(bus1.mem_addr), 32'(addr_before));
    @(negedge clk);
    chk("zero_done_drop", 32'(bus1.done), 32'd0);

    // Reset while byte 7 of the second word (address 0x201 -> 0x17) is shown.
    bus1.sample_ready = 1'b1;
    drive_start(0, 1'b1, 14'h0200, 14'd4);
    @(negedge clk);
    drive_start(0, 1'b0, 14'h0200, 14'd4);
    hit = 0;
    for (int c = 0; c < 200 && !hit; c++) begin
      if (bus1.sample_valid && bus1.sample_data == 8'h17) hit = 1;
      else @(negedge clk);
    end
    chk("reach_word2_byte7", 32'(hit), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(bus1.mem_addr), 32'd0);
    chk("mid_rst_data", 32'(bus1.sample_data), 32'd0);
    chk("mid_rst_valid", 32'(bus1.sample_valid), 32'd0);
    chk("mid_rst_busy", 32'(bus1.busy), 32'd0);
    chk("mid_rst_done", 32'(bus1.done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bad_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus1.done || bus1.sample_valid || bus1.busy) bad_done = 1;
    end
    chk("post_rst_quiet", 32'(bad_done), 32'd0);
    run_stream(0, 14'h0305, 14'd1, 0, 0, 8'h50, 14'h0305);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
